// File: rtl/multicycle_ctrl.sv
// ============================================================================
//  Module   : multicycle_ctrl
//  Purpose  : Main control FSM for a multi-cycle MIPS datapath (fetch, decode,
//             execute, memory, writeback) with retired-instruction counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             BranchNe,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_EXEC_I    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_ILLEGAL   = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d = opcode;
        case (opcode)
          OP_LW, OP_SW:                    state_d = S_MEM_ADDR;
          OP_RTYPE:                        state_d = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI,
          OP_XORI, OP_SLTI, OP_SLTIU:      state_d = S_EXEC_I;
          OP_BEQ, OP_BNE:                  state_d = S_BRANCH;
          OP_J:                            state_d = S_JUMP;
          default:                         state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  state_d = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXEC_R:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_EXEC_I:    state_d = S_I_WB;
      S_I_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_ILLEGAL:   state_d = S_ILLEGAL;
      default:     state_d = S_ILLEGAL;
    endcase
    // Every state that can reach FETCH (other than FETCH itself) ends an instruction.
    retire    = (state_d == S_FETCH) && (state_q != S_FETCH);
    cnt_d     = cnt_q + CNT_W'(retire);
    illegal_d = illegal_q | (state_d == S_ILLEGAL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 3'b000;
    PCSource    = 2'b00;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE:    ALUSrcB = 2'b11;
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b111;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (op_q)
          OP_ANDI:  ALUOp = 3'b010;
          OP_ORI:   ALUOp = 3'b011;
          OP_XORI:  ALUOp = 3'b100;
          OP_SLTI:  ALUOp = 3'b101;
          OP_SLTIU: ALUOp = 3'b110;
          default:  ALUOp = 3'b000;
        endcase
      end
      S_I_WB:      RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 3'b001;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        BranchNe    = (op_q == OP_BNE);
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: ;
    endcase
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
    end
  end

  assign illegal     = illegal_q;
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
//  Module   : tb_multicycle_ctrl
//  Purpose  : Self-checking bench for multicycle_ctrl using an instruction-level
//             reference model (per-instruction state traces and retire count).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSource;
  logic [2:0]  ALUOp;
  logic        illegal;
  logic [3:0]  state;
  logic [31:0] instr_count;

  int tests  = 0;
  int errors = 0;
  int model_cnt = 0;

  localparam logic [5:0] LEGAL_OPS [12] = '{6'h23, 6'h2b, 6'h00, 6'h08, 6'h0c, 6'h0d,
                                            6'h0e, 6'h0a, 6'h0b, 6'h04, 6'h05, 6'h02};

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .illegal(illegal), .state(state),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  logic [17:0] act_ctrl;
  assign act_ctrl = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
                     MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  logic [5:0] strobes;
  assign strobes = {PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite};

  // Instruction class: 0 lw, 1 sw, 2 R, 3 I-type, 4 branch, 5 jump, 6 unsupported
  function automatic int op_class(input logic [5:0] op);
    case (op)
      6'h23: return 0;
      6'h2b: return 1;
      6'h00: return 2;
      6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h0b: return 3;
      6'h04, 6'h05: return 4;
      6'h02: return 5;
      default: return 6;
    endcase
  endfunction

  function automatic logic [2:0] i_aluop(input logic [5:0] op);
    case (op)
      6'h0c:   return 3'b010;
      6'h0d:   return 3'b011;
      6'h0e:   return 3'b100;
      6'h0a:   return 3'b101;
      6'h0b:   return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [17:0] exp_ctrl(input int st, input logic [5:0] op, input logic mr);
    logic pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 3'b000;
    case (st)
      0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = 3'b111; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin asa = 1; asb = 2'b10; aop = i_aluop(op); end
      9:  rw = 1;
      10: begin asa = 1; aop = 3'b001; pcwc = 1; pcs = 2'b01; bne = (op == 6'b000101); end
      11: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs};
  endfunction

  // Runs one instruction from FETCH; entered and left 1 time unit after a rising edge.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input string name);
    int   st_q[$];
    logic mr_q[$];
    int   cls = op_class(op);
    for (int i = 0; i < fw; i++) begin st_q.push_back(0); mr_q.push_back(1'b0); end
    st_q.push_back(0); mr_q.push_back(1'b1);
    st_q.push_back(1); mr_q.push_back(1'($urandom));
    case (cls)
      0: begin
        st_q.push_back(2); mr_q.push_back(1'($urandom));
        for (int i = 0; i < mw; i++) begin st_q.push_back(3); mr_q.push_back(1'b0); end
        st_q.push_back(3); mr_q.push_back(1'b1);
        st_q.push_back(4); mr_q.push_back(1'($urandom));
      end
      1: begin
        st_q.push_back(2); mr_q.push_back(1'($urandom));
        for (int i = 0; i < mw; i++) begin st_q.push_back(5); mr_q.push_back(1'b0); end
        st_q.push_back(5); mr_q.push_back(1'b1);
      end
      2: begin st_q.push_back(6); mr_q.push_back(1'($urandom));
               st_q.push_back(7); mr_q.push_back(1'($urandom)); end
      3: begin st_q.push_back(8); mr_q.push_back(1'($urandom));
               st_q.push_back(9); mr_q.push_back(1'($urandom)); end
      4: begin st_q.push_back(10); mr_q.push_back(1'($urandom)); end
      default: begin st_q.push_back(11); mr_q.push_back(1'($urandom)); end
    endcase
    foreach (st_q[i]) begin
      mem_ready = mr_q[i];
      opcode    = (st_q[i] == 1) ? op : 6'($urandom);
      #1;
      tests++;
      if (state !== 4'(st_q[i])) begin
        errors++;
        $display("FAIL %s cyc%0d state: got %0d expected %0d", name, i, state, st_q[i]);
      end
      tests++;
      if (act_ctrl !== exp_ctrl(st_q[i], op, mr_q[i])) begin
        errors++;
        $display("FAIL %s cyc%0d ctrl: got %b expected %b", name, i, act_ctrl,
                 exp_ctrl(st_q[i], op, mr_q[i]));
      end
      tests++;
      if (instr_count !== 32'(model_cnt) || illegal !== 1'b0) begin
        errors++;
        $display("FAIL %s cyc%0d count/illegal: got %0d/%b expected %0d/0", name, i,
                 instr_count, illegal, model_cnt);
      end
      @(posedge clk); #1;
    end
    model_cnt++;
    tests++;
    if (state !== 4'd0 || instr_count !== 32'(model_cnt)) begin
      errors++;
      $display("FAIL %s retire: got state %0d count %0d expected state 0 count %0d",
               name, state, instr_count, model_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'($urandom);
    @(posedge clk); #1; @(posedge clk); #1;
    tests++;
    if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    tests++;
    if (instr_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", instr_count); end
    tests++;
    if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
    tests++;
    if (strobes !== 6'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 000000", strobes); end
    rst = 1'b0;
    model_cnt = 0;
  endtask

  task automatic test_r_type();
    run_instr(6'b000000, 0, 0, "r_type");
    tests++;
    if (instr_count !== 32'd1) begin errors++; $display("FAIL r_type_count: got %0d expected 1", instr_count); end
  endtask

  task automatic test_lw_stall();
    run_instr(6'b100011, 0, 2, "lw_stall");
  endtask

  task automatic test_itype();
    run_instr(6'b001101, 0, 0, "ori");
    run_instr(6'b001011, 0, 0, "sltiu");
    tests++;
    if (instr_count !== 32'd4) begin errors++; $display("FAIL itype_count: got %0d expected 4", instr_count); end
  endtask

  task automatic test_branch();
    run_instr(6'b000101, 1, 0, "bne");
    run_instr(6'b000100, 0, 0, "beq");
    run_instr(6'b000010, 2, 0, "jump");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_instr(LEGAL_OPS[$urandom_range(0, 11)], $urandom_range(0, 2), $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_illegal();
    logic [5:0] op;
    for (int pass = 0; pass < 2; pass++) begin
      op = 6'h3f;
      if (pass == 1) begin
        do op = 6'($urandom); while (op_class(op) != 6);
      end
      mem_ready = 1'b1; opcode = op;
      @(posedge clk); #1;
      tests++;
      if (state !== 4'd1) begin errors++; $display("FAIL illegal_decode: got %0d expected 1", state); end
      @(posedge clk); #1;
      for (int k = 0; k < 10; k++) begin
        mem_ready = 1'($urandom); opcode = 6'($urandom);
        #1;
        tests++;
        if (state !== 4'd15 || strobes !== 6'b0) begin
          errors++;
          $display("FAIL illegal_hold cyc%0d: got state %0d strobes %b expected 15 000000", k, state, strobes);
        end
        if (k > 0) begin
          tests++;
          if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag cyc%0d: got %b expected 1", k, illegal); end
        end
        @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_cnt = 0;
      tests++;
      if (state !== 4'd0 || illegal !== 1'b0 || instr_count !== 32'd0) begin
        errors++;
        $display("FAIL illegal_clear: got state %0d illegal %b count %0d expected 0 0 0", state, illegal, instr_count);
      end
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0; model_cnt = 0;
    opcode = 6'b101011;
    for (int k = 0; k < 3; k++) begin
      mem_ready = 1'b1;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    #1;
    tests++;
    if (state !== 4'd5 || MemWrite !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: got state %0d MemWrite %b expected 5 1", state, MemWrite);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (MemWrite !== 1'b0) begin errors++; $display("FAIL mid_forced: got MemWrite %b expected 0", MemWrite); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    tests++;
    if (state !== 4'd0 || MemWrite !== 1'b0 || instr_count !== 32'd0) begin
      errors++;
      $display("FAIL mid_post: got state %0d MemWrite %b count %0d expected 0 0 0", state, MemWrite, instr_count);
    end
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0; opcode = 6'd0;
    test_reset();
    test_r_type();
    test_lw_stall();
    test_itype();
    test_branch();
    test_random();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

`default_nettype wire
